// File: rtl/ex_stage_if.sv
// Purpose: bundles the execute-stage upstream op bus and downstream result bus.
// Latency: none (wires only); timing is defined by the stage that drives it.
// Backpressure: in_ready/out_ready carry valid-ready flow control in each direction.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    // upstream (decode) side
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            branch;
    logic [4:0]      rd;
    logic            reg_write;
    logic            flush;

    // downstream (memory stage) side
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic            out_branch_taken;
    logic [XLEN-1:0] out_branch_target;
    logic [4:0]      out_rd;
    logic            out_reg_write;
    logic            out_illegal;

    // environment view: issues ops, consumes results
    modport master (
        output in_valid, alu_control, operand_a, operand_b, pc, imm,
               branch, rd, reg_write, flush, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_branch_taken,
               out_branch_target, out_rd, out_reg_write, out_illegal
    );

    // execute stage view
    modport slave (
        input  in_valid, alu_control, operand_a, operand_b, pc, imm,
               branch, rd, reg_write, flush, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_branch_taken,
               out_branch_target, out_rd, out_reg_write, out_illegal
    );
endinterface

// File: rtl/ex_stage.sv
// Purpose: RISC-V execute stage - ALU op, beq resolve, branch target, 2-entry elastic output buffer.
// Latency: 1 cycle from accept to out_valid when the buffer is empty; 1 op/cycle sustained.
// Backpressure: in_ready is registered (buffer not full), so out_ready never reaches in_ready combinationally.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_stage_if.slave bus
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            branch_taken;
        logic [XLEN-1:0] target;
        logic [4:0]      rd;
        logic            reg_write;
        logic            illegal;
    } ex_res_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t state_q, state_nxt;
    logic       in_ready_q;
    logic       out_valid_q;
    ex_res_t    ent0_q, ent1_q;   // ent0 is always the head
    ex_res_t    res_new;
    ex_res_t    head;
    logic       accept, pop;
    logic       wr0, wr1, shift;

    assign accept = bus.in_valid && in_ready_q && !bus.flush;
    assign pop    = out_valid_q && bus.out_ready;

    // ALU, zero flag, beq resolution and target for the op on the input bus
    always_comb begin
        res_new         = '0;
        res_new.illegal = 1'b0;
        case (bus.alu_control)
            ALU_ADD: res_new.result = bus.operand_a + bus.operand_b;
            ALU_SUB: res_new.result = bus.operand_a - bus.operand_b;
            ALU_XOR: res_new.result = bus.operand_a ^ bus.operand_b;
            ALU_OR:  res_new.result = bus.operand_a | bus.operand_b;
            ALU_AND: res_new.result = bus.operand_a & bus.operand_b;
            default: begin
                res_new.result  = '0;
                res_new.illegal = 1'b1;
            end
        endcase
        res_new.zero         = (res_new.result == '0);
        res_new.branch_taken = bus.branch && res_new.zero && !res_new.illegal;
        // target is computed even for non-branch and illegal ops
        res_new.target       = bus.pc + bus.imm;
        res_new.rd           = bus.rd;
        // branch ops keep their reg_write; only illegal ops are suppressed
        res_new.reg_write    = bus.reg_write && !res_new.illegal;
    end

    // buffer occupancy FSM: next state and entry write/shift strobes
    always_comb begin
        state_nxt = state_q;
        wr0       = 1'b0;
        wr1       = 1'b0;
        shift     = 1'b0;
        if (bus.flush) begin
            // a pop in this cycle is still consumed downstream; incoming op dropped
            state_nxt = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        wr0       = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        wr0       = 1'b1;
                    end else if (accept) begin
                        wr1       = 1'b1;
                        state_nxt = FULL;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        shift     = 1'b1;
                        state_nxt = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // state register plus registered handshake outputs derived from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            in_ready_q  <= (state_nxt != FULL);
            out_valid_q <= (state_nxt != EMPTY);
        end
    end

    // entry storage: load head/tail or advance tail into head on pop from full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            if (wr0) begin
                ent0_q <= res_new;
            end else if (shift) begin
                ent0_q <= ent1_q;
            end
            if (wr1) begin
                ent1_q <= res_new;
            end
        end
    end

    // empty buffer presents all-zero data, so stale entries never leak out
    assign head = out_valid_q ? ent0_q : '0;

    assign bus.in_ready          = in_ready_q;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_result        = head.result;
    assign bus.out_zero          = head.zero;
    assign bus.out_branch_taken  = head.branch_taken;
    assign bus.out_branch_target = head.target;
    assign bus.out_rd            = head.rd;
    assign bus.out_reg_write     = head.reg_write;
    assign bus.out_illegal       = head.illegal;

endmodule

// File: tb/tb_ex_stage.sv
// Purpose: directed self-checking bench for ex_stage.
// Latency: inputs change 1ns after the rising edge; outputs sampled at the same point.
// Backpressure: exercised by holding out_ready low against back-to-back ops.
module tb_ex_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ex_stage_if #(.XLEN(32)) bus ();

    ex_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // valid head with full field comparison
    task automatic chk_head(input string tag, input logic [31:0] res, input logic z,
                            input logic tk, input logic [31:0] tgt, input logic [4:0] r,
                            input logic rw, input logic ill);
        chk({tag, ".valid"},  32'(bus.out_valid), 32'd1);
        chk({tag, ".result"}, bus.out_result, res);
        chk({tag, ".zero"},   32'(bus.out_zero), 32'(z));
        chk({tag, ".taken"},  32'(bus.out_branch_taken), 32'(tk));
        chk({tag, ".target"}, bus.out_branch_target, tgt);
        chk({tag, ".rd"},     32'(bus.out_rd), 32'(r));
        chk({tag, ".rw"},     32'(bus.out_reg_write), 32'(rw));
        chk({tag, ".ill"},    32'(bus.out_illegal), 32'(ill));
    endtask

    // empty buffer: no valid, every data output zero
    task automatic chk_empty(input string tag);
        chk({tag, ".valid"},  32'(bus.out_valid), 32'd0);
        chk({tag, ".result"}, bus.out_result, 32'd0);
        chk({tag, ".zero"},   32'(bus.out_zero), 32'd0);
        chk({tag, ".taken"},  32'(bus.out_branch_taken), 32'd0);
        chk({tag, ".target"}, bus.out_branch_target, 32'd0);
        chk({tag, ".rd"},     32'(bus.out_rd), 32'd0);
        chk({tag, ".rw"},     32'(bus.out_reg_write), 32'd0);
        chk({tag, ".ill"},    32'(bus.out_illegal), 32'd0);
    endtask

    task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] i, input logic br,
                      input logic [4:0] r, input logic rw);
        bus.in_valid    = 1'b1;
        bus.alu_control = c;
        bus.operand_a   = a;
        bus.operand_b   = b;
        bus.pc          = p;
        bus.imm         = i;
        bus.branch      = br;
        bus.rd          = r;
        bus.reg_write   = rw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.alu_control  = 4'b0000;
        bus.operand_a    = '0;
        bus.operand_b    = '0;
        bus.pc           = '0;
        bus.imm          = '0;
        bus.branch       = 1'b0;
        bus.rd           = '0;
        bus.reg_write    = 1'b0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b1;

        // reset state
        #12;
        chk_empty("rst");
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD 5+7, pc 0x40 imm 4
        op(4'b0010, 32'd5, 32'd7, 32'h40, 32'h4, 1'b0, 5'd3, 1'b1);
        tick();
        chk_head("add", 32'd12, 1'b0, 1'b0, 32'h44, 5'd3, 1'b1, 1'b0);
        chk("add.in_ready", 32'(bus.in_ready), 32'd1);

        // SUB 7-7 accepted while ADD pops
        op(4'b0110, 32'd7, 32'd7, 32'h0, 32'h0, 1'b0, 5'd4, 1'b1);
        tick();
        chk_head("sub", 32'd0, 1'b1, 1'b0, 32'h0, 5'd4, 1'b1, 1'b0);

        // beq taken, negative offset
        op(4'b0110, 32'h10, 32'h10, 32'h100, 32'hFFFF_FFF8, 1'b1, 5'd0, 1'b0);
        tick();
        chk_head("beq_t", 32'd0, 1'b1, 1'b1, 32'hF8, 5'd0, 1'b0, 1'b0);

        // beq not taken, target unchanged
        op(4'b0110, 32'h11, 32'h10, 32'h100, 32'hFFFF_FFF8, 1'b1, 5'd0, 1'b0);
        tick();
        chk_head("beq_nt", 32'd1, 1'b0, 1'b0, 32'hF8, 5'd0, 1'b0, 1'b0);

        // ADD wraps to zero
        op(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 1'b0, 5'd5, 1'b1);
        tick();
        chk_head("wrap", 32'd0, 1'b1, 1'b0, 32'h0, 5'd5, 1'b1, 1'b0);

        // logic ops
        op(4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0, 1'b0, 5'd6, 1'b1);
        tick();
        chk_head("xor", 32'hFF00_FF00, 1'b0, 1'b0, 32'h0, 5'd6, 1'b1, 1'b0);
        op(4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0, 1'b0, 5'd7, 1'b1);
        tick();
        chk_head("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 32'h0, 5'd7, 1'b1, 1'b0);
        op(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0, 1'b0, 5'd8, 1'b1);
        tick();
        chk_head("and", 32'h00F0_00F0, 1'b0, 1'b0, 32'h0, 5'd8, 1'b1, 1'b0);

        // illegal codes with reg_write and branch set; target still computed
        op(4'b1111, 32'd9, 32'd9, 32'h200, 32'h10, 1'b1, 5'd9, 1'b1);
        tick();
        chk_head("ill_f", 32'd0, 1'b1, 1'b0, 32'h210, 5'd9, 1'b0, 1'b1);
        op(4'b0101, 32'd3, 32'd4, 32'h200, 32'h10, 1'b1, 5'd10, 1'b1);
        tick();
        chk_head("ill_5", 32'd0, 1'b1, 1'b0, 32'h210, 5'd10, 1'b0, 1'b1);

        // drain: buffer empties and outputs return to zero
        bus.in_valid = 1'b0;
        tick();
        chk_empty("drain");

        // back-pressure: three back-to-back ops with out_ready low
        bus.out_ready = 1'b0;
        op(4'b0010, 32'd1, 32'd0, 32'h0, 32'h0, 1'b0, 5'd1, 1'b1);
        tick();
        chk_head("bp_a", 32'd1, 1'b0, 1'b0, 32'h0, 5'd1, 1'b1, 1'b0);
        chk("bp_a.in_ready", 32'(bus.in_ready), 32'd1);
        op(4'b0010, 32'd2, 32'd0, 32'h0, 32'h0, 1'b0, 5'd2, 1'b1);
        tick();
        chk("bp_b.in_ready", 32'(bus.in_ready), 32'd0);
        chk_head("bp_b_head", 32'd1, 1'b0, 1'b0, 32'h0, 5'd1, 1'b1, 1'b0);
        op(4'b0010, 32'd3, 32'd0, 32'h0, 32'h0, 1'b0, 5'd3, 1'b1);
        tick();
        chk("bp_c.in_ready", 32'(bus.in_ready), 32'd0);
        chk_head("bp_c_hold", 32'd1, 1'b0, 1'b0, 32'h0, 5'd1, 1'b1, 1'b0);

        // release: A pops, C still blocked this cycle
        bus.out_ready = 1'b1;
        tick();
        chk_head("rel_b", 32'd2, 1'b0, 1'b0, 32'h0, 5'd2, 1'b1, 1'b0);
        chk("rel_b.in_ready", 32'(bus.in_ready), 32'd1);
        // C accepted while B pops at count 1: count stays 1
        tick();
        chk_head("rel_c", 32'd3, 1'b0, 1'b0, 32'h0, 5'd3, 1'b1, 1'b0);
        chk("rel_c.in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        tick();
        chk_empty("rel_done");

        // flush with two buffered and an op offered
        bus.out_ready = 1'b0;
        op(4'b0010, 32'd10, 32'd0, 32'h0, 32'h0, 1'b0, 5'd11, 1'b1);
        tick();
        op(4'b0010, 32'd20, 32'd0, 32'h0, 32'h0, 1'b0, 5'd12, 1'b1);
        tick();
        chk("fl_full.in_ready", 32'(bus.in_ready), 32'd0);
        op(4'b0010, 32'd30, 32'd0, 32'h0, 32'h0, 1'b0, 5'd13, 1'b1);
        bus.flush = 1'b1;
        tick();
        chk_empty("flush");
        chk("flush.in_ready", 32'(bus.in_ready), 32'd1);
        // flush with in_ready high: offered op must still be dropped
        bus.out_ready = 1'b1;
        op(4'b0010, 32'd35, 32'd0, 32'h0, 32'h0, 1'b0, 5'd14, 1'b1);
        tick();
        chk_empty("flush_rdy");
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk_empty("post_flush");

        // recovery after flush
        bus.out_ready = 1'b0;
        op(4'b0010, 32'd40, 32'd0, 32'h0, 32'h0, 1'b0, 5'd15, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk_head("recov", 32'd40, 1'b0, 1'b0, 32'h0, 5'd15, 1'b1, 1'b0);

        // asynchronous reset mid-cycle, no clock edge in between
        #2;
        rst_n = 1'b0;
        #1;
        chk_empty("arst");
        chk("arst.in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_empty("arst_rel");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
